// File: rtl/keypad_sync_debounce.sv
`timescale 1ns/1ps
// keypad_sync_debounce
//
// Per-channel conditioner for raw keypad row/column pins. Each channel goes
// through a multi-flop synchroniser, a debounce counter that only accepts a
// new level after it has persisted for DEBOUNCE_CYCLES enabled cycles, and a
// registered rise/fall edge detector.
//
// Ports
//   clk      system clock, all state updates on posedge
//   rst      asynchronous active-low reset
//   en       debounce enable tick (synchroniser runs regardless)
//   din      raw asynchronous inputs, WIDTH channels
//   q        debounced, synchronised levels
//   rise     one-cycle pulse when q[i] goes 0->1
//   fall     one-cycle pulse when q[i] goes 1->0
//   changed  OR of all rise/fall pulses, registered with them
module keypad_sync_debounce #(
    parameter int   WIDTH           = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int               CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RESET_VAL}};

    if (WIDTH < 1) begin : g_bad_width
        $error("keypad_sync_debounce: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("keypad_sync_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("keypad_sync_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0]                  s;

    logic [WIDTH-1:0][CW-1:0] cnt_p1;
    logic [WIDTH-1:0][CW-1:0] cnt_next;
    logic [WIDTH-1:0]         q_next;
    logic [WIDTH-1:0]         rise_next;
    logic [WIDTH-1:0]         fall_next;
    logic                     changed_next;

    // ---- stage p0: synchroniser chain, free-running, no logic between flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= {SYNC_STAGES{RST_WORD}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_p0[SYNC_STAGES-1];

    // ---- stage p1: debounce decision and edge pulses
    // The count measures how long s has disagreed with q. Any agreement
    // discards the partial count, so a bounce restarts the wait. The count
    // is cleared when it reaches its last value, so it never wraps.
    always_comb begin
        cnt_next  = cnt_p1;
        q_next    = q;
        rise_next = '0;
        fall_next = '0;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == q[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt_p1[i] == CNT_LAST) begin
                    cnt_next[i]  = '0;
                    q_next[i]    = s[i];
                    rise_next[i] = s[i];
                    fall_next[i] = ~s[i];
                end else begin
                    cnt_next[i] = cnt_p1[i] + CW'(1);
                end
            end
        end
        changed_next = |(rise_next | fall_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p1  <= '0;
            q       <= RST_WORD;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            cnt_p1  <= cnt_next;
            q       <= q_next;
            rise    <= rise_next;
            fall    <= fall_next;
            changed <= changed_next;
        end
    end

endmodule
